// File: rtl/multi_channel_debouncer.sv
// N-channel push-button conditioner: synchroniser, stability filter, press/release/event pulses.
// Optional LONG_PRESS_EN adds a per-channel long-hold detector (long_press port, HOLD_CYCLES).
module multi_channel_debouncer #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 50000
`ifdef LONG_PRESS_EN
    ,
    parameter int unsigned HOLD_CYCLES   = 100000000
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] noisy_in,
    input  logic [1:0]      edge_mode,
    output logic [N_CH-1:0] clean_level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] event_pulse
`ifdef LONG_PRESS_EN
    ,
    output logic [N_CH-1:0] long_press
`endif
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
    logic [N_CH-1:0]                  synced;
    logic [N_CH-1:0][CNT_W-1:0]       cnt_q;
    logic [N_CH-1:0][CNT_W-1:0]       cnt_d;
    logic [N_CH-1:0]                  clean_q;
    logic [N_CH-1:0]                  clean_d;
    logic [N_CH-1:0]                  press_q;
    logic [N_CH-1:0]                  press_d;
    logic [N_CH-1:0]                  release_q;
    logic [N_CH-1:0]                  release_d;

    // Metastability chain; stage 0 samples the raw pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], noisy_in};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Stability filter: a differing level must persist STABLE_CYCLES edges to be accepted.
    always_comb begin
        cnt_d     = cnt_q;
        clean_d   = clean_q;
        press_d   = '0;
        release_d = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (synced[ch] == clean_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_W'(STABLE_CYCLES - 1)) begin
                cnt_d[ch]     = '0;
                clean_d[ch]   = synced[ch];
                press_d[ch]   = synced[ch];
                release_d[ch] = ~synced[ch];
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            clean_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            clean_q   <= clean_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign clean_level   = clean_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    // Mode mask is applied after the pulse registers so edge_mode acts in the same cycle.
    assign event_pulse   = (press_q   & {N_CH{edge_mode[0]}})
                         | (release_q & {N_CH{edge_mode[1]}});

`ifdef LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    logic [N_CH-1:0][HOLD_W-1:0] hold_q;
    logic [N_CH-1:0][HOLD_W-1:0] hold_d;
    logic [N_CH-1:0]             long_q;
    logic [N_CH-1:0]             long_d;

    // Hold counter equals (cycles clean_level has been high) - 1, saturating at HOLD_CYCLES-1.
    always_comb begin
        hold_d = hold_q;
        long_d = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (!clean_d[ch]) begin
                hold_d[ch] = '0;
            end else if (!clean_q[ch]) begin
                hold_d[ch] = '0;
                long_d[ch] = (HOLD_CYCLES == 1);
            end else if (hold_q[ch] != HOLD_W'(HOLD_CYCLES - 1)) begin
                hold_d[ch] = hold_q[ch] + HOLD_W'(1);
                long_d[ch] = (hold_d[ch] == HOLD_W'(HOLD_CYCLES - 1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            long_q <= '0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_press = long_q;
`endif

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Scoreboard bench for multi_channel_debouncer: stimulus pushes expected pulse records,
// a monitor pops and compares whenever any pulse output is active.
module tb_multi_channel_debouncer;

    localparam int unsigned N_CH          = 2;
    localparam int unsigned SYNC_STAGES   = 2;
    localparam int unsigned STABLE_CYCLES = 4;
`ifdef LONG_PRESS_EN
    localparam int unsigned HOLD_CYCLES   = 10;
`endif

    typedef struct {
        int         cyc;
        logic [1:0] clean;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] ev;
        logic [1:0] lp;
    } exp_t;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic [1:0] noisy_in  = 2'b11;
    logic [1:0] edge_mode = 2'b00;
    logic [1:0] clean_level;
    logic [1:0] press_pulse;
    logic [1:0] release_pulse;
    logic [1:0] event_pulse;
`ifdef LONG_PRESS_EN
    logic [1:0] long_press;
`endif
    logic [1:0] lp_act;

    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   c      = 0;
    exp_t sb[$];
    exp_t mon_e;

    multi_channel_debouncer #(
        .N_CH          (N_CH),
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
`ifdef LONG_PRESS_EN
        ,
        .HOLD_CYCLES   (HOLD_CYCLES)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .noisy_in      (noisy_in),
        .edge_mode     (edge_mode),
        .clean_level   (clean_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .event_pulse   (event_pulse)
`ifdef LONG_PRESS_EN
        ,
        .long_press    (long_press)
`endif
    );

    always #5 clk = ~clk;

    // Edge counter: after the k-th rising edge cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

`ifdef LONG_PRESS_EN
    assign lp_act = long_press;
`else
    assign lp_act = 2'b00;
`endif

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic go(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input int at, input logic [1:0] cl, input logic [1:0] pr,
                             input logic [1:0] rl, input logic [1:0] ev, input logic [1:0] lp);
        exp_t e;
        e.cyc   = at;
        e.clean = cl;
        e.press = pr;
        e.rel   = rl;
        e.ev    = ev;
        e.lp    = lp;
        sb.push_back(e);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete within time limit (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst && ((press_pulse | release_pulse | event_pulse | lp_act) != 2'b00)) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_output: got press=%b rel=%b ev=%b lp=%b expected none (cycle %0d)",
                                 press_pulse, release_pulse, event_pulse, lp_act, cyc);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("pulse_cycle",   cyc,                 mon_e.cyc);
                        chk("clean_level",   int'(clean_level),   int'(mon_e.clean));
                        chk("press_pulse",   int'(press_pulse),   int'(mon_e.press));
                        chk("release_pulse", int'(release_pulse), int'(mon_e.rel));
                        chk("event_pulse",   int'(event_pulse),   int'(mon_e.ev));
`ifdef LONG_PRESS_EN
                        chk("long_press",    int'(lp_act),        int'(mon_e.lp));
`endif
                    end
                end
            end
        join_none

        // Reset held with both inputs high: everything stays 0.
        repeat (5) begin
            @(negedge clk);
            chk("reset_outputs", int'({clean_level, press_pulse, release_pulse, event_pulse}), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        c   = cyc;
        expect_ev(c + 6, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        go(c + 5);
        @(negedge clk);
        chk("pre_accept_clean", int'(clean_level), 0);

        go(c + 6);
        noisy_in = 2'b00;
        c = cyc;
        expect_ev(c + 6, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);

        // Clean step on ch0 with press events enabled.
        go(c + 8);
        c = cyc;
        edge_mode = 2'b01;
        noisy_in  = 2'b01;
        expect_ev(c + 6, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00);
        go(c + 6);
        noisy_in = 2'b00;
        c = cyc;
        expect_ev(c + 6, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);

        // Bouncy ch0: 3 high, 1 low, 3 high must be rejected.
        go(c + 8);
        c = cyc;
        noisy_in = 2'b01;
        go(c + 3);
        noisy_in = 2'b00;
        go(c + 4);
        noisy_in = 2'b01;
        go(c + 7);
        noisy_in = 2'b00;
        go(c + 11);
        @(negedge clk);
        chk("glitch_filtered", int'(clean_level), 0);
        go(c + 12);
        c = cyc;
        noisy_in = 2'b01;
        expect_ev(c + 6, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00);
        go(c + 6);
        noisy_in = 2'b00;
        c = cyc;
        expect_ev(c + 6, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);

        // ch1 under each edge_mode.
        go(c + 8);
        c = cyc;
        edge_mode = 2'b10;
        noisy_in  = 2'b10;
        expect_ev(c + 6, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        go(c + 6);
        noisy_in = 2'b00;
        c = cyc;
        expect_ev(c + 6, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00);

        go(c + 8);
        c = cyc;
        edge_mode = 2'b11;
        noisy_in  = 2'b10;
        expect_ev(c + 6, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00);
        go(c + 6);
        noisy_in = 2'b00;
        c = cyc;
        expect_ev(c + 6, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00);

        go(c + 8);
        c = cyc;
        edge_mode = 2'b00;
        noisy_in  = 2'b10;
        expect_ev(c + 6, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        go(c + 6);
        noisy_in = 2'b00;
        c = cyc;
        expect_ev(c + 6, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
        go(c + 7);
        edge_mode = 2'b11;

        // Long hold on ch0, then release and hold again.
        go(c + 10);
        c = cyc;
        edge_mode = 2'b01;
        noisy_in  = 2'b01;
        expect_ev(c + 6, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00);
`ifdef LONG_PRESS_EN
        expect_ev(c + 15, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
`endif
        go(c + 25);
        noisy_in = 2'b00;
        expect_ev(c + 31, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);

        go(c + 33);
        c = cyc;
        noisy_in = 2'b01;
        expect_ev(c + 6, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00);
`ifdef LONG_PRESS_EN
        expect_ev(c + 15, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
`endif
        go(c + 16);
        noisy_in = 2'b00;
        expect_ev(c + 22, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);

        // Reset mid-count: ch1 clean high, ch0 counter at 2.
        go(c + 24);
        c = cyc;
        noisy_in = 2'b10;
        expect_ev(c + 6, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00);
        go(c + 6);
        noisy_in = 2'b11;
        go(c + 10);
        rst = 1'b1;
        #1;
        chk("reset_mid_count", int'({clean_level, press_pulse, release_pulse, event_pulse}), 0);
        go(c + 12);
        rst = 1'b0;
        c = cyc;
        expect_ev(c + 6, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00);
        go(c + 5);
        @(negedge clk);
        chk("post_reset_full_period", int'(clean_level), 0);
        go(c + 6);
        noisy_in = 2'b00;
        c = cyc;
        expect_ev(c + 6, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);

        go(c + 10);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule
